mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multicycle signed MULT/DIV engine with architectural HI/LO registers for the multicycle MIPS core.
//  The control unit pulses mult_start/div_start from its MULT/DIV states with operands taken from regs A/B.
//  It then holds in a wait state until done. MFHI/MFLO read hi/lo through the MemToReg mux.
//  Radix-2 iterative: one partial step per clock.
// PARAMETERS
//  WIDTH    32               operand / HI / LO width
//  CNT_W    $clog2(WIDTH)+1  iteration counter width (derived localparam, not overridable)
// PORTS
//  clk         in   1      core clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  mult_start  in   1      start signed multiply of a*b (1-cycle pulse)
//  div_start   in   1      start signed divide a/b (1-cycle pulse)
//  a           in   WIDTH  operand rs (dividend / multiplicand), sampled with start
//  b           in   WIDTH  operand rt (divisor / multiplier), sampled with start
//  busy        out  1      operation in progress; starts ignored while high
//  done        out  1      1-cycle pulse; hi/lo hold new result in the same cycle
//  hi          out  WIDTH  HI register: product[63:32] or remainder
//  lo          out  WIDTH  LO register: product[31:0] or quotient
//  div_zero    out  1      divide-by-zero pulse, coincident with done (DIVZERO_TRAP_EN only)
// BEHAVIOUR
//  Reset: async, active-high; one clock, clk; rst forces state IDLE.
//   Outputs at reset: busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
//   Asserting rst mid-operation aborts the operation; no done pulse is produced.
//  FSM:
//   IDLE -> MUL on mult_start; IDLE -> DIV on div_start.
//   mult_start has priority when both starts are high in the same cycle.
//   MUL/DIV run one iteration per cycle. After WIDTH iterations (counter==WIDTH-1): -> FIX.
//   FIX -> IDLE: apply signs, write hi/lo, done=1 for exactly one cycle.
//  Start handling:
//   On the start edge (E0), latch |a|, |b|, sign(a), sign(b); clear the accumulator; set busy=1.
//   Starts are ignored in every state other than IDLE.
//   A start in the same cycle as done (state IDLE next) is accepted one cycle later only; no back-to-back overlap.
//  Latency:
//   Iterations occur at E1..E32; the FIX writeback occurs at E33.
//   busy=1 between E0 and E33; done=1 and busy=0 in the cycle after E33.
//   Fixed 33 cycles for both MULT and DIV, independent of operand values.
//  MUL:
//   Unsigned shift-add on magnitudes into a 2*WIDTH accumulator.
//   Result negated (2's complement, 64-bit) if sign(a)^sign(b).
//   hi=result[63:32], lo=result[31:0].
//  DIV:
//   Restoring division on magnitudes.
//   Quotient negated if sign(a)^sign(b); remainder negated if sign(a) (the remainder takes the dividend's sign).
//   lo=quotient, hi=remainder.
//   |0x80000000| = 0x80000000 held as an unsigned magnitude.
//   0x80000000/-1 gives lo=0x80000000, hi=0 (wraps, no overflow flag).
//  hi/lo change only at FIX (or reset); they are stable and readable at all other times.
// CONFIGURATION
//  DIVZERO_TRAP_EN defined:
//   div_start with b==0 skips iteration: DIV -> FIX on the next cycle.
//   hi/lo are left unchanged; done=1 and div_zero=1 are pulsed together.
//   The control unit routes div_zero to its exception path.
//  DIVZERO_TRAP_EN undefined:
//   The div_zero port is absent; divide-by-zero runs the full 33 cycles.
//   Result: lo=0xFFFFFFFF if a>=0, else 0x00000001; hi=a.
// STRUCTURE
//  Shared package mips_pkg:
//   MD_IDLE/MD_MUL/MD_DIV/MD_FIX state encoding.
//   Funct constants FUNCT_MULT=6'h18, FUNCT_DIV=6'h1a, FUNCT_MFHI=6'h10, FUNCT_MFLO=6'h12.
//   WORD_W=32.
//  No sub-module: FSM, shift datapath and sign-fix stay in one file.
//  A separate negation helper is not warranted.
// TESTING
//  1 mult_start, a=7, b=-3 -> done 33 cycles later; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy low with done.
//  2 div_start, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//    Then a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
//  3 mult_start, a=b=0x80000000 -> hi=0x40000000, lo=0.
//    a=b=0xFFFFFFFF -> hi=0, lo=1.
//  4 Second start pulse at cycle 10 of a busy MULT -> ignored; first result intact; no second done.
//    mult_start and div_start in the same cycle -> multiply performed.
//  5 rst asserted at cycle 20 of a DIV -> busy=0, hi=lo=0 immediately (async), no done.
//    A new MULT 4*5 afterwards -> lo=20.
//  6 div_start, b=0, a=9:
//    with DIVZERO_TRAP_EN -> done+div_zero two cycles after start, hi/lo unchanged;
//    without -> lo=0xFFFFFFFF, hi=9 after 33 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and widths for the multicycle MIPS core
package mips_pkg;
    localparam int WORD_W = 32;
    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1a;
    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;
    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_FIX} md_state_t;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: radix-2 multicycle signed MULT/DIV with HI/LO registers
// ports: clk, rst (async high); mult_start/div_start pulses with operands a/b;
//        busy, done (1-cycle), hi/lo results; div_zero only with DIVZERO_TRAP_EN
module mult_div_unit import mips_pkg::*; #(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef DIVZERO_TRAP_EN
    ,
    output logic             div_zero
`endif
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    md_state_t          r_state;
    logic               r_is_mul, r_sa, r_sb;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
`ifdef DIVZERO_TRAP_EN
    logic               r_dz;
`endif
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo, w_rmd;
    logic [WIDTH:0]     w_sum, w_rem, w_diff;
    logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
    // acc holds {partial, multiplier-shift} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        w_abs_a    = a[WIDTH-1] ? -a : a;
        w_abs_b    = b[WIDTH-1] ? -b : b;
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
        w_mul_next = {w_sum, r_acc[WIDTH-1:1]};
        w_rem      = r_acc[2*WIDTH-1:WIDTH-1];
        w_diff     = w_rem - {1'b0, r_b};
        w_div_next = {w_diff[WIDTH] ? w_rem[WIDTH-1:0] : w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
        w_prod     = (r_sa ^ r_sb) ? -r_acc : r_acc;
        w_quo      = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rmd      = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= MD_IDLE;
            r_is_mul <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef DIVZERO_TRAP_EN
            r_dz     <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef DIVZERO_TRAP_EN
            div_zero <= 1'b0;
`endif
            case (r_state)
                MD_IDLE: if (mult_start || div_start) begin
                    r_is_mul <= mult_start;
                    r_sa     <= a[WIDTH-1];
                    r_sb     <= b[WIDTH-1];
                    r_a      <= w_abs_a;
                    r_b      <= w_abs_b;
                    r_acc    <= mult_start ? '0 : {{WIDTH{1'b0}}, w_abs_a};
                    r_cnt    <= '0;
                    busy     <= 1'b1;
                    r_state  <= mult_start ? MD_MUL : MD_DIV;
`ifdef DIVZERO_TRAP_EN
                    r_dz     <= !mult_start && (b == '0);
`endif
                end
                MD_MUL, MD_DIV: begin
                    r_acc <= r_is_mul ? w_mul_next : w_div_next;
                    r_b   <= r_is_mul ? r_b >> 1 : r_b;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) r_state <= MD_FIX;
`ifdef DIVZERO_TRAP_EN
                    if (r_dz) r_state <= MD_FIX;
`endif
                end
                MD_FIX: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= MD_IDLE;
`ifdef DIVZERO_TRAP_EN
                    div_zero <= r_dz;
                    if (!r_dz) begin
                        hi <= r_is_mul ? w_prod[2*WIDTH-1:WIDTH] : w_rmd;
                        lo <= r_is_mul ? w_prod[WIDTH-1:0] : w_quo;
                    end
`else
                    hi <= r_is_mul ? w_prod[2*WIDTH-1:WIDTH] : w_rmd;
                    lo <= r_is_mul ? w_prod[WIDTH-1:0] : w_quo;
`endif
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    logic        clk = 1'b0, rst = 1'b0, mult_start = 1'b0, div_start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
`ifdef DIVZERO_TRAP_EN
    logic        div_zero;
`endif
    int          n_chk = 0, n_pass = 0, cyc = 0, t0 = 0;
    logic [63:0] sb_q[$];
    logic [63:0] shadow = '0;
    mult_div_unit dut (
        .clk(clk), .rst(rst), .mult_start(mult_start), .div_start(div_start),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef DIVZERO_TRAP_EN
        , .div_zero(div_zero)
`endif
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    function automatic logic [63:0] model(input logic m, input logic [31:0] av, input logic [31:0] bv);
        longint sa = longint'($signed(av));
        longint sb = longint'($signed(bv));
        logic [31:0] q, r;
        if (m) return 64'(sa * sb);
        if (bv == 0) return {av, av[31] ? 32'h1 : 32'hFFFF_FFFF};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
    endfunction
    task automatic start_op(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        mult_start = m;
        div_start  = d;
        a = av;
        b = bv;
        @(negedge clk);
        mult_start = 1'b0;
        div_start  = 1'b0;
        t0 = cyc;
    endtask
    task automatic wait_done(input string tag, input int exp_lat);
        logic [63:0] e;
        while (!done && cyc - t0 < 100) @(negedge clk);
        chk({tag, "_lat"}, 64'(cyc - t0), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_sbq"}, 64'(sb_q.size()), 64'(1));
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
            chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
            shadow = e;
        end
    endtask
    task automatic do_op(input string tag, input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
        sb_q.push_back(model(m, av, bv));
        start_op(m, d, av, bv);
        wait_done(tag, 33);
    endtask
    task automatic count_dones(input string tag, input int n);
        int nd = 0;
        repeat (n) begin
            @(negedge clk);
            nd += int'(done);
        end
        chk(tag, 64'(nd), 64'(0));
    endtask
    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hilo", {hi, lo}, 64'(0));
`ifdef DIVZERO_TRAP_EN
        chk("rst_dz", 64'(div_zero), 64'(0));
`endif
        rst = 1'b0;
        do_op("mul_7_m3", 1, 0, 32'd7, -32'sd3);
        chk("mul_7_m3_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op("div_m7_2", 0, 1, -32'sd7, 32'd2);
        chk("div_m7_2_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_min_m1_val", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op("mul_min_min", 1, 0, 32'h8000_0000, 32'h8000_0000);
        chk("mul_min_min_val", {hi, lo}, 64'h4000_0000_0000_0000);
        do_op("mul_m1_m1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mul_m1_m1_val", {hi, lo}, 64'h0000_0000_0000_0001);
        do_op("div_100_m7", 0, 1, 32'd100, -32'sd7);
        for (int i = 0; i < 4; i++)
            do_op($sformatf("rnd%0d", i), i[0], !i[0], $urandom, $urandom_range(1, 1000) - 500);
        sb_q.push_back(model(1, 32'd123, 32'd456));
        start_op(1, 0, 32'd123, 32'd456);
        repeat (9) @(negedge clk);
        mult_start = 1'b1;
        a = 32'd5;
        b = 32'd5;
        @(negedge clk);
        mult_start = 1'b0;
        chk("ign_busy", 64'(busy), 64'(1));
        wait_done("ign", 33);
        count_dones("ign_no_2nd_done", 40);
        chk("ign_hilo_hold", {hi, lo}, shadow);
        do_op("both_start", 1, 1, 32'd6, 32'd7);
        chk("both_start_val", {hi, lo}, 64'd42);
        start_op(0, 1, 32'd1000, 32'd3);
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_hilo", {hi, lo}, 64'(0));
        shadow = '0;
        @(negedge clk);
        rst = 1'b0;
        count_dones("abort_no_done", 40);
        do_op("mul_4_5", 1, 0, 32'd4, 32'd5);
        chk("mul_4_5_lo", 64'(lo), 64'd20);
`ifdef DIVZERO_TRAP_EN
        chk("mul_dz_low", 64'(div_zero), 64'(0));
        sb_q.push_back(shadow);
        start_op(0, 1, 32'd9, 32'd0);
        wait_done("dz_trap", 2);
        chk("dz_flag", 64'(div_zero), 64'(1));
        @(negedge clk);
        chk("dz_pulse", 64'(div_zero), 64'(0));
`else
        do_op("div_9_0", 0, 1, 32'd9, 32'd0);
        chk("div_9_0_val", {hi, lo}, 64'h0000_0009_FFFF_FFFF);
        do_op("div_m5_0", 0, 1, -32'sd5, 32'd0);
        chk("div_m5_0_val", {hi, lo}, 64'hFFFF_FFFB_0000_0001);
`endif
        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
